dram_refresh_arbiter: RTL and testbench
=======================================

Name: dram_refresh_arbiter

Overview:
- Synchronous refresh scheduler and access/refresh arbiter for the FastRAM DRAM array.
- Sits between the bus-cycle decode (which raises ACCESS_REQ for a matched 68000 RAM cycle) and the RAS/CAS output drivers.
- Guarantees the CAS-before-RAS refresh rate by counting refresh debt and paying it back in bus-idle windows.
- Grants normal accesses when no refresh is in progress.

Parameters:
- REF_INTERVAL, 110: CLK cycles between refresh ticks (15.5 us at 7.09 MHz).
- MAX_PENDING, 8: saturation limit of the owed-refresh counter (1..15).
- CAS_LEAD, 1: cycles REF_CAS is asserted before REF_RAS.
- RAS_CYCLES, 2: cycles REF_RAS and REF_CAS are asserted together.
- PRECHARGE, 2: cycles both strobes are deasserted before returning to IDLE.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, synchronous, active-high.
- BUS_IDLE  in  1  CLK-synchronous; high when the 68000 address strobe is negated.
- ACCESS_REQ  in  1  decoded RAM cycle request; held until the bus cycle ends.
- ACCESS_GNT  out  1  access may drive RAS/CAS.
- REF_CAS  out  1  refresh CAS, active-high (inverted by the driver).
- REF_RAS  out  1  refresh RAS, active-high.
- REF_BUSY  out  1  refresh sequence in progress (any state other than IDLE or ACCESS).
- REF_PENDING  out  4  owed refreshes.
- REF_OVERRUN  out  1  sticky: a tick was lost at saturation.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; REF_PENDING=0.
  - Interval counter loaded with REF_INTERVAL-1.
  - Reset asserted mid-sequence drops REF_RAS/REF_CAS on the next edge.
- Interval counter:
  - Decrements every CLK.
  - At 0: reloads REF_INTERVAL-1 and issues a one-cycle tick.
- Pending counter:
  - Tick increments it, saturating at MAX_PENDING; a tick at saturation sets REF_OVERRUN (cleared only by RESET).
  - Refresh completion (PRECHARGE to IDLE) decrements it.
  - Tick and completion in the same cycle: value unchanged, no overrun.
- States:
  - IDLE, ACCESS, CAS_PRE, RAS_ON, PRECHARGE.
- IDLE:
  - ACCESS_REQ=1 → ACCESS; ACCESS_GNT=1 in the next cycle.
  - Else if REF_PENDING>0 and BUS_IDLE=1 → CAS_PRE.
  - Else if REF_PENDING==MAX_PENDING → CAS_PRE regardless of BUS_IDLE (urgent).
  - Access has priority over refresh when both are eligible in the same cycle, except when urgent: urgent refresh wins and ACCESS_REQ waits.
- ACCESS:
  - ACCESS_GNT=1 while ACCESS_REQ=1.
  - ACCESS_REQ=0 → IDLE; ACCESS_GNT=0 in the following cycle.
  - Refresh never starts from ACCESS.
- CAS_PRE:
  - REF_CAS=1, REF_RAS=0 for CAS_LEAD cycles → RAS_ON.
- RAS_ON:
  - REF_CAS=1, REF_RAS=1 for RAS_CYCLES cycles → PRECHARGE.
- PRECHARGE:
  - Both strobes 0 for PRECHARGE cycles → IDLE, with a decrement pulse.
- During a refresh sequence:
  - ACCESS_REQ is ignored.
  - ACCESS_GNT stays 0.
  - The sequence always completes; it cannot be aborted except by RESET.
- REF_BUSY=1 in CAS_PRE, RAS_ON and PRECHARGE.
- Invariants:
  - REF_RAS never asserts without REF_CAS having been high on the previous cycle.
  - ACCESS_GNT and REF_BUSY are never both 1.
- All outputs are registered.
- Latency from IDLE with pending>0 and BUS_IDLE to first REF_CAS is 1 cycle.

Test Plan:
- Reset, bus idle, no requests → first REF_CAS at cycle REF_INTERVAL+1. Sequence is CAS 1, RAS+CAS 2, idle 2. REF_PENDING goes 1→0 at sequence end.
- Hold BUS_IDLE=0 and ACCESS_REQ=0 for 8×110 cycles → REF_PENDING climbs to 8. The urgent refresh starts in the cycle after reaching 8. Sequences run back-to-back down to 0; REF_OVERRUN=0.
- Hold ACCESS_REQ=1 continuously for 10×110 cycles → REF_PENDING saturates at 8 and REF_OVERRUN=1. On ACCESS_REQ release, ACCESS_GNT drops after 1 cycle and refreshes then drain.
- ACCESS_REQ rises in CAS_PRE → ACCESS_GNT stays 0 through PRECHARGE and asserts 1 cycle after IDLE is reached.
- Force a tick in the same cycle as a refresh completion with REF_PENDING=3 → REF_PENDING stays 3.
- Assert RESET during RAS_ON → REF_RAS=REF_CAS=0 after the next edge, REF_PENDING=0, and the interval restarts from REF_INTERVAL-1.

Source files
------------

// File: rtl/dram_refresh_arbiter.sv
// Refresh scheduler and access/refresh arbiter for the FastRAM DRAM array.
// Counts owed CAS-before-RAS refreshes and pays them back in bus-idle windows.
//
// state       | meaning
// S_IDLE      | no activity; choose between access and refresh
// S_ACCESS    | bus cycle owns RAS/CAS, grant held while request stays high
// S_CAS_PRE   | refresh CAS asserted ahead of RAS
// S_RAS_ON    | refresh RAS and CAS asserted together
// S_PRECHARGE | both strobes low before returning to idle
module dram_refresh_arbiter #(
  parameter int REF_INTERVAL = 110,
  parameter int MAX_PENDING  = 8,
  parameter int CAS_LEAD     = 1,
  parameter int RAS_CYCLES   = 2,
  parameter int PRECHARGE    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bus_idle,
  input  logic       i_access_req,
  output logic       o_access_gnt,
  output logic       o_ref_cas,
  output logic       o_ref_ras,
  output logic       o_ref_busy,
  output logic [3:0] o_ref_pending,
  output logic       o_ref_overrun
);

  localparam int IW = $clog2(REF_INTERVAL);
  localparam logic [IW-1:0] INT_RELOAD = IW'(REF_INTERVAL - 1);
  localparam logic [3:0]    MAX_P      = 4'(MAX_PENDING);
  localparam logic [3:0]    CAS_LOAD   = 4'(CAS_LEAD - 1);
  localparam logic [3:0]    RAS_LOAD   = 4'(RAS_CYCLES - 1);
  localparam logic [3:0]    PRE_LOAD   = 4'(PRECHARGE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAS_PRE,
    S_RAS_ON,
    S_PRECHARGE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_phase;
  logic [3:0]    w_next_phase;
  logic [IW-1:0] r_int_cnt;
  logic [3:0]    r_pending;
  logic          r_overrun;
  logic          r_gnt;
  logic          r_cas;
  logic          r_ras;
  logic          r_busy;
  logic          w_tick;
  logic          w_done;
  logic          w_urgent;

  assign w_tick   = (r_int_cnt == '0);
  assign w_urgent = (r_pending == MAX_P);
  assign w_done   = (r_state == S_PRECHARGE) && (r_phase == 4'd0);

  always_comb begin
    w_next_state = r_state;
    w_next_phase = (r_phase != 4'd0) ? r_phase - 4'd1 : 4'd0;
    case (r_state)
      S_IDLE: begin
        // Saturated debt outranks a pending bus access.
        if (w_urgent) begin
          w_next_state = S_CAS_PRE;
          w_next_phase = CAS_LOAD;
        end else if (i_access_req) begin
          w_next_state = S_ACCESS;
        end else if ((r_pending != 4'd0) && i_bus_idle) begin
          w_next_state = S_CAS_PRE;
          w_next_phase = CAS_LOAD;
        end
      end
      S_ACCESS: begin
        if (!i_access_req) w_next_state = S_IDLE;
      end
      S_CAS_PRE: begin
        if (r_phase == 4'd0) begin
          w_next_state = S_RAS_ON;
          w_next_phase = RAS_LOAD;
        end
      end
      S_RAS_ON: begin
        if (r_phase == 4'd0) begin
          w_next_state = S_PRECHARGE;
          w_next_phase = PRE_LOAD;
        end
      end
      S_PRECHARGE: begin
        if (r_phase == 4'd0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_phase <= 4'd0;
      r_gnt   <= 1'b0;
      r_cas   <= 1'b0;
      r_ras   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_gnt   <= (w_next_state == S_ACCESS);
      r_cas   <= (w_next_state == S_CAS_PRE) || (w_next_state == S_RAS_ON);
      r_ras   <= (w_next_state == S_RAS_ON);
      r_busy  <= (w_next_state == S_CAS_PRE) || (w_next_state == S_RAS_ON) ||
                 (w_next_state == S_PRECHARGE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_int_cnt <= INT_RELOAD;
      r_pending <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      r_int_cnt <= w_tick ? INT_RELOAD : r_int_cnt - IW'(1);
      if (w_tick && !w_done) begin
        if (r_pending == MAX_P) r_overrun <= 1'b1;
        else                    r_pending <= r_pending + 4'd1;
      end else if (w_done && !w_tick && (r_pending != 4'd0)) begin
        r_pending <= r_pending - 4'd1;
      end
    end
  end

  assign o_access_gnt  = r_gnt;
  assign o_ref_cas     = r_cas;
  assign o_ref_ras     = r_ras;
  assign o_ref_busy    = r_busy;
  assign o_ref_pending = r_pending;
  assign o_ref_overrun = r_overrun;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Self-checking bench for dram_refresh_arbiter: table of timed input phases with
// expected outputs queued at drive time and popped when the phase ends.
module tb_dram_refresh_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_bus_idle = 1'b1;
  logic       i_access_req = 1'b0;
  logic       o_access_gnt;
  logic       o_ref_cas;
  logic       o_ref_ras;
  logic       o_ref_busy;
  logic [3:0] o_ref_pending;
  logic       o_ref_overrun;

  dram_refresh_arbiter dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_bus_idle    (i_bus_idle),
    .i_access_req  (i_access_req),
    .o_access_gnt  (o_access_gnt),
    .o_ref_cas     (o_ref_cas),
    .o_ref_ras     (o_ref_ras),
    .o_ref_busy    (o_ref_busy),
    .o_ref_pending (o_ref_pending),
    .o_ref_overrun (o_ref_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       gnt;
    logic       cas;
    logic       ras;
    logic       busy;
    logic [3:0] pend;
    logic       ovr;
  } exp_t;

  typedef struct {
    logic rst;
    logic bi;
    logic rq;
    int   cyc;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic prev_cas = 1'b0;

  task automatic v(input logic rst, input logic bi, input logic rq, input int cyc,
                   input logic gnt, input logic cas, input logic ras, input logic busy,
                   input logic [3:0] pend, input logic ovr);
    vec_t t;
    t.rst = rst; t.bi = bi; t.rq = rq; t.cyc = cyc;
    t.e = '{gnt: gnt, cas: cas, ras: ras, busy: busy, pend: pend, ovr: ovr};
    tbl.push_back(t);
  endtask

  // Called at a negedge: drive, queue expectation, advance, compare at a negedge.
  task automatic apply(input vec_t t, input string name);
    exp_t act;
    exp_t exp_v;
    i_reset      = t.rst;
    i_bus_idle   = t.bi;
    i_access_req = t.rq;
    sb.push_back(t.e);
    repeat (t.cyc) @(posedge i_clk);
    @(negedge i_clk);
    act = '{gnt: o_access_gnt, cas: o_ref_cas, ras: o_ref_ras, busy: o_ref_busy,
            pend: o_ref_pending, ovr: o_ref_overrun};
    exp_v = sb.pop_front();
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got gnt=%b cas=%b ras=%b busy=%b pend=%0d ovr=%b, want gnt=%b cas=%b ras=%b busy=%b pend=%0d ovr=%b",
               name, act.gnt, act.cas, act.ras, act.busy, act.pend, act.ovr,
               exp_v.gnt, exp_v.cas, exp_v.ras, exp_v.busy, exp_v.pend, exp_v.ovr);
    end
  endtask

  // Grant/busy exclusion and RAS-after-CAS ordering, every cycle out of reset.
  always @(negedge i_clk) begin
    if (mon_en && !i_reset) begin
      checks++;
      if ((o_access_gnt && o_ref_busy) || (o_ref_ras && !prev_cas)) begin
        errors++;
        $display("FAIL invariant: gnt=%b busy=%b ras=%b prev_cas=%b, want gnt&busy=0 and ras only after cas",
                 o_access_gnt, o_ref_busy, o_ref_ras, prev_cas);
      end
    end
    prev_cas = o_ref_cas;
  end

  initial begin
    vec_t h;
    // rst bi rq cycles | gnt cas ras busy pend ovr
    // first refresh after reset with the bus idle
    v(1,1,0,   2, 0,0,0,0,0,0);
    v(0,1,0, 110, 0,0,0,0,1,0);
    v(0,1,0,   1, 0,1,0,1,1,0);
    v(0,1,0,   1, 0,1,1,1,1,0);
    v(0,1,0,   1, 0,1,1,1,1,0);
    v(0,1,0,   1, 0,0,0,1,1,0);
    v(0,1,0,   1, 0,0,0,1,1,0);
    v(0,1,0,   1, 0,0,0,0,0,0);
    // access request raised during CAS_PRE waits for the sequence to finish
    v(1,1,0,   2, 0,0,0,0,0,0);
    v(0,1,0, 111, 0,1,0,1,1,0);
    v(0,1,1,   4, 0,0,0,1,1,0);
    v(0,1,1,   1, 0,0,0,0,0,0);
    v(0,1,1,   1, 1,0,0,0,0,0);
    v(0,1,0,   1, 0,0,0,0,0,0);
    // bus busy: debt climbs to the limit, urgent refresh, then drain
    v(1,1,0,   2, 0,0,0,0,0,0);
    v(0,0,0, 880, 0,0,0,0,8,0);
    v(0,0,0,   1, 0,1,0,1,8,0);
    v(0,0,0,   5, 0,0,0,0,7,0);
    v(0,1,0,   1, 0,1,0,1,7,0);
    v(0,1,0,  41, 0,0,0,0,0,0);
    // continuous access: saturation and overrun, release then drain
    v(1,1,0,   2, 0,0,0,0,0,0);
    v(0,1,1,   1, 1,0,0,0,0,0);
    v(0,1,1,1099, 1,0,0,0,8,1);
    v(0,1,0,   1, 0,0,0,0,8,1);
    v(0,1,0,   1, 0,1,0,1,8,1);
    v(0,1,0,  47, 0,0,0,0,0,1);
    // reset in RAS_ON drops strobes and restarts the interval
    v(1,1,0,   2, 0,0,0,0,0,0);
    v(0,1,0, 112, 0,1,1,1,1,0);
    v(1,1,0,   1, 0,0,0,0,0,0);
    v(0,1,0, 110, 0,0,0,0,1,0);
    v(0,1,0,   1, 0,1,0,1,1,0);

    @(negedge i_clk);
    mon_en = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Refresh completion lands on the same edge as tick #4 with three owed.
    h.rst = 1'b1; h.bi = 1'b1; h.rq = 1'b0; h.cyc = 2;
    h.e = '{gnt: 1'b0, cas: 1'b0, ras: 1'b0, busy: 1'b0, pend: 4'd0, ovr: 1'b0};
    apply(h, "coincide_reset");
    h.rst = 1'b0; h.bi = 1'b0; h.cyc = 330; h.e.pend = 4'd3;
    apply(h, "coincide_owed3");
    h.cyc = 104;
    apply(h, "coincide_hold");
    h.bi = 1'b1; h.cyc = 1; h.e.cas = 1'b1; h.e.busy = 1'b1;
    apply(h, "coincide_start");
    h.cyc = 5; h.e.cas = 1'b0; h.e.busy = 1'b0;
    apply(h, "coincide_same_edge");
    h.cyc = 1; h.e.cas = 1'b1; h.e.busy = 1'b1;
    apply(h, "coincide_next");
    h.cyc = 5; h.e.cas = 1'b0; h.e.busy = 1'b0; h.e.pend = 4'd2;
    apply(h, "coincide_after");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
